// File: rtl/vga_timing_if.sv
// Raster timing bundle from the VGA timing generator to the pixel/bit generators.
interface vga_timing_if;
    localparam int unsigned CNT_W = 10;

    logic             pix_en;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             bright;
    logic             frame_start;

    modport master (
        output pix_en, hcount, vcount, hsync, vsync, bright, frame_start
    );

    modport slave (
        input  pix_en, hcount, vcount, hsync, vsync, bright, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA timing: pixel-rate enable, raster counters, active-low syncs,
// visible-window flag and a per-frame start pulse, all registered.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10
) (
    input  logic                clk,
    input  logic                reset,
    vga_timing_if.master        vga_o
);
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_VIS_LO = H_SYNC + H_BP;
    localparam int unsigned H_VIS_HI = H_VIS_LO + H_ACTIVE;
    localparam int unsigned V_VIS_LO = V_SYNC + V_BP;
    localparam int unsigned V_VIS_HI = V_VIS_LO + V_ACTIVE;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic             PIX_EN_RST = (CLK_DIV == 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_param_err
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             pix_en_q, pix_en_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             bright_q, bright_d;
    logic             frame_start_q, frame_start_d;

    // Decodes use the next-state counts so each flag lines up with the count it describes.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        hcount_d  = hcount_q;
        vcount_d  = vcount_q;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end

        if (pix_en_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end

        pix_en_d      = (div_cnt_d == DIV_LAST);
        hsync_d       = (hcount_d >= CNT_W'(H_SYNC));
        vsync_d       = (vcount_d >= CNT_W'(V_SYNC));
        bright_d      = ({1'b0, hcount_d} >= (CNT_W+1)'(H_VIS_LO)) &&
                        ({1'b0, hcount_d} <  (CNT_W+1)'(H_VIS_HI)) &&
                        ({1'b0, vcount_d} >= (CNT_W+1)'(V_VIS_LO)) &&
                        ({1'b0, vcount_d} <  (CNT_W+1)'(V_VIS_HI));
        frame_start_d = pix_en_d && (hcount_d == '0) && (vcount_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q     <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            pix_en_q      <= PIX_EN_RST;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            bright_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            pix_en_q      <= pix_en_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            bright_q      <= bright_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_o.pix_en      = pix_en_q;
    assign vga_o.hcount      = hcount_q;
    assign vga_o.vcount      = vcount_q;
    assign vga_o.hsync       = hsync_q;
    assign vga_o.vsync       = vsync_q;
    assign vga_o.bright      = bright_q;
    assign vga_o.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (default, CLK_DIV=1, small raster) checked every
// clock against an arithmetic model of elapsed pixels, with random async reset pulses.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       pix_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       hsync;
        logic       vsync;
        logic       bright;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    longint t0 = 0, t1 = 0, t2 = 0, cyc = 0;
    longint fs2_last = -1;

    always #5 clk = ~clk;

    vga_timing_if if0 ();
    vga_timing_if if1 ();
    vga_timing_if if2 ();

    vga_timing_gen u0 (.clk(clk), .reset(rst0), .vga_o(if0));

    vga_timing_gen #(.CLK_DIV(1)) u1 (.clk(clk), .reset(rst1), .vga_o(if1));

    vga_timing_gen #(
        .CLK_DIV(3), .H_SYNC(4), .H_BP(3), .H_ACTIVE(10), .H_FP(2),
        .V_SYNC(1), .V_BP(2), .V_ACTIVE(5), .V_FP(2)
    ) u2 (.clk(clk), .reset(rst2), .vga_o(if2));

    // Expected outputs after t clk edges since reset release: t/div pixels have elapsed.
    function automatic exp_t model(longint t, int div, int hs, int hb, int ha, int hf,
                                   int vs, int vb, int va, int vf);
        exp_t   e;
        longint ht, vt, p;
        int     hh, vv;
        ht = longint'(hs + hb + ha + hf);
        vt = longint'(vs + vb + va + vf);
        p  = (t / longint'(div)) % (ht * vt);
        hh = int'(p % ht);
        vv = int'(p / ht);
        e.pix_en = ((t + 1) % longint'(div)) == 0;
        e.h      = 10'(hh);
        e.v      = 10'(vv);
        e.hsync  = hh >= hs;
        e.vsync  = vv >= vs;
        e.bright = (hh >= hs + hb) && (hh < hs + hb + ha) && (vv >= vs + vb) && (vv < vs + vb + va);
        e.fs     = e.pix_en && hh == 0 && vv == 0 && t > 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmp(input string name, input exp_t o, input exp_t e);
        chk({name, ".pix_en"}, 32'(o.pix_en), 32'(e.pix_en));
        chk({name, ".hcount"}, 32'(o.h), 32'(e.h));
        chk({name, ".vcount"}, 32'(o.v), 32'(e.v));
        chk({name, ".hsync"},  32'(o.hsync), 32'(e.hsync));
        chk({name, ".vsync"},  32'(o.vsync), 32'(e.vsync));
        chk({name, ".bright"}, 32'(o.bright), 32'(e.bright));
        chk({name, ".frame_start"}, 32'(o.fs), 32'(e.fs));
    endtask

    task automatic check_all();
        exp_t o0, o1, o2;
        o0 = {if0.pix_en, if0.hcount, if0.vcount, if0.hsync, if0.vsync, if0.bright, if0.frame_start};
        o1 = {if1.pix_en, if1.hcount, if1.vcount, if1.hsync, if1.vsync, if1.bright, if1.frame_start};
        o2 = {if2.pix_en, if2.hcount, if2.vcount, if2.hsync, if2.vsync, if2.bright, if2.frame_start};
        cmp("u0", o0, model(t0, 2, 96, 48, 640, 16, 2, 33, 480, 10));
        cmp("u1", o1, model(t1, 1, 96, 48, 640, 16, 2, 33, 480, 10));
        cmp("u2", o2, model(t2, 3, 4, 3, 10, 2, 1, 2, 5, 2));
    endtask

    // One clock: advance elapsed-edge counts of units not in reset, then sample at +1.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst0) t0++;
        if (!rst1) t1++;
        if (!rst2) t2++;
        #1;
        check_all();
        if (rst2) begin
            fs2_last = -1;
        end else if (if2.frame_start) begin
            if (fs2_last >= 0) chk("u2_frame_period_clks", 32'(cyc - fs2_last), 32'd570);
            fs2_last = cyc;
        end
    endtask

    // Changes resets 3 time units after an edge, i.e. between clk edges.
    task automatic set_rst(input logic r0, input logic r1, input logic r2);
        #2;
        rst0 = r0; rst1 = r1; rst2 = r2;
        if (r0) t0 = 0;
        if (r1) t1 = 0;
        if (r2) t2 = 0;
        #1;
        if (r0 | r1 | r2) check_all();
    endtask

    initial begin
        int hs_low;
        int n;
        int mask;
        int hold;

        repeat (3) tick();
        chk("u0_reset_hcount", 32'(if0.hcount), 32'd0);
        chk("u0_reset_hsync",  32'(if0.hsync),  32'd0);
        set_rst(1'b0, 1'b0, 1'b0);

        tick();
        chk("u0_first_pix_en", 32'(if0.pix_en), 32'd1);
        tick();
        chk("u0_hcount_after_first_pix", 32'(if0.hcount), 32'd1);

        hs_low = (if0.hsync == 1'b0) ? 2 : 0;
        for (int i = 3; i <= 1600; i++) begin
            tick();
            if (if0.hsync == 1'b0) hs_low++;
            if (i == 800) begin
                chk("u1_line_wrap_hcount", 32'(if1.hcount), 32'd0);
                chk("u1_line_wrap_vcount", 32'(if1.vcount), 32'd1);
            end
        end
        chk("u0_hsync_low_clks", 32'(hs_low), 32'd192);
        chk("u0_line_wrap_hcount", 32'(if0.hcount), 32'd0);
        chk("u0_line_wrap_vcount", 32'(if0.vcount), 32'd1);

        repeat (1700) tick();

        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(150, 1500));
            repeat (n) tick();
            mask = int'($urandom_range(1, 7));
            hold = int'($urandom_range(1, 3));
            set_rst(mask[0], mask[1], mask[2]);
            chk("mid_reset_u0_hcount", 32'(mask[0] ? if0.hcount : 10'd0), 32'd0);
            chk("mid_reset_u2_vcount", 32'(mask[2] ? if2.vcount : 10'd0), 32'd0);
            repeat (hold) tick();
            set_rst(1'b0, 1'b0, 1'b0);
        end

        repeat (700) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
